// File: rtl/display_scan_mux_pkg.sv
// -----------------------------------------------------------------------------
// display_scan_mux_pkg
//
// Shared definitions for the 4-digit seven-segment display scan path.
// Holds the digit count, the all-anodes-off pattern, the default divisor
// values (also used by the clock-divider blocks) and small helpers that
// build the per-slot anode pattern.
// -----------------------------------------------------------------------------
package display_scan_mux_pkg;

    // Number of multiplexed digits on the display.
    localparam int NUM_DIGITS = 4;

    // Width of the slot index (0..NUM_DIGITS-1).
    localparam int IDX_W = $clog2(NUM_DIGITS);

    // Anode enables are active-low: all ones means every digit is dark.
    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    // Default divisors for a 100 MHz system clock.
    //  - refresh: 100000 cycles per digit slot -> 1 kHz per digit
    //  - blink  : 25000000 cycles per phase    -> 2 Hz blink
    localparam int DEF_REFRESH_DIV = 100000;
    localparam int DEF_BLINK_DIV   = 25000000;

    // Registered slot outputs, grouped so the next-state mux reads cleanly.
    typedef struct packed {
        logic [3:0] digit;
        logic [3:0] an;
        logic       dp_n;
    } slot_out_t;

    // Reset value of the slot outputs: dark display, digit 0, dp off.
    localparam slot_out_t SLOT_OUT_RESET = '{
        digit: 4'd0,
        an:    AN_ALL_OFF,
        dp_n:  1'b1
    };

    // Active-low one-hot anode pattern for slot k.
    function automatic logic [3:0] an_for_slot(input logic [IDX_W-1:0] k);
        logic [3:0] onehot;
        onehot = 4'b0001 << k;
        return ~onehot;
    endfunction

    // Bit offset of the nibble that belongs to slot k inside {d3,d2,d1,d0}.
    function automatic logic [3:0] nibble_lsb(input logic [IDX_W-1:0] k);
        return {k, 2'b00};
    endfunction

endpackage

// File: rtl/display_scan_mux_tick_gen.sv
// -----------------------------------------------------------------------------
// display_scan_mux_tick_gen
//
// Free-running prescaler that emits a one-cycle tick every DIV clock cycles.
// The counter runs 0..DIV-1 and tick is high during the terminal-count cycle,
// so the first tick arrives DIV cycles after reset is released. With DIV=1
// the counter is stuck at 0 and tick is high every cycle.
//
// Parameters
//   DIV   clock cycles per tick, >= 1
//
// Ports
//   clk   in   1   system clock
//   rst   in   1   synchronous, active-high reset (counter -> 0)
//   tick  out  1   high in the terminal-count cycle
// -----------------------------------------------------------------------------
module display_scan_mux_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // At least one bit so DIV=1 still gives a legal vector.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    // Exact terminal value; the counter wraps here, so it never overflows.
    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc = (r_cnt == TC);
    assign tick = w_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// -----------------------------------------------------------------------------
// display_scan_mux
//
// Time-multiplexes four 4-bit digit values onto the single shared
// seven_segment decoder and drives the active-low anode enables of the
// 4-digit display. Adds frame-coherent sampling (a shadow copy of the digits
// taken once per frame), per-digit blink for adjust mode, leading-zero
// blanking of the leftmost digit and decimal-point control.
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot, >= 1
//   BLINK_DIV    clk cycles per blink-phase toggle, >= 1
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   digits_in    in   16  {d3,d2,d1,d0}; d0 = rightmost digit, on an[0]
//   blink_mask   in   4   1 = digit blanks during the blink off-phase
//   dp_mask      in   4   1 = decimal point lit on that digit
//   blank_lead   in   1   1 = blank d3 when it equals 0
//   digit        out  4   value fed to seven_segment.digit
//   an           out  4   anode enables, active-low, one-hot-low or all 1
//   dp_n         out  1   decimal point, active-low
//   frame_start  out  1   one-cycle pulse on the edge that loads the shadow
// -----------------------------------------------------------------------------
module display_scan_mux
    import display_scan_mux_pkg::*;
#(
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int BLINK_DIV   = DEF_BLINK_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lead,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        frame_start
);

    // ------------------------------------------------------------------
    // Prescalers
    // ------------------------------------------------------------------
    logic w_refresh_tick;
    logic w_blink_tick;

    display_scan_mux_tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_refresh_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_refresh_tick)
    );

    display_scan_mux_tick_gen #(
        .DIV (BLINK_DIV)
    ) u_blink_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_blink_tick)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] r_idx;          // slot currently on the display
    logic [15:0]      r_shadow;       // frame-coherent copy of digits_in
    logic             r_blink_phase;  // 1 = blink off-phase
    slot_out_t        r_out;          // registered digit/an/dp_n
    logic             r_frame_start;

    // ------------------------------------------------------------------
    // Next-slot computation (only committed on a refresh tick)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_next_idx;
    logic             w_frame_edge;
    logic [15:0]      w_src;
    logic [3:0]       w_next_digit;
    logic             w_lead_zero;
    logic             w_blanked;
    slot_out_t        w_next_out;

    assign w_next_idx   = r_idx + IDX_W'(1);

    // Leaving slot 3 means the next slot is 0 and a new frame begins.
    assign w_frame_edge = (r_idx == IDX_W'(NUM_DIGITS - 1));

    // Slot 0 of a new frame reads digits_in directly, because the shadow
    // register is being loaded on that very edge and would otherwise show
    // the previous frame's d0 for one slot.
    assign w_src        = w_frame_edge ? digits_in : r_shadow;

    assign w_next_digit = w_src[nibble_lsb(w_next_idx) +: 4];

    // Leading-zero test uses the d3 value that slot 3 will actually show,
    // i.e. the shadow copy, so the blanking decision stays frame-coherent.
    assign w_lead_zero  = (w_next_idx == IDX_W'(NUM_DIGITS - 1))
                        && blank_lead
                        && (w_src[15:12] == 4'd0);

    assign w_blanked    = (r_blink_phase && blink_mask[w_next_idx]) || w_lead_zero;

    always_comb begin
        w_next_out       = SLOT_OUT_RESET;
        // digit keeps its value even when blanked; the dark anodes hide it.
        w_next_out.digit = w_next_digit;
        w_next_out.an    = w_blanked ? AN_ALL_OFF : an_for_slot(w_next_idx);
        w_next_out.dp_n  = w_blanked | ~dp_mask[w_next_idx];
    end

    // ------------------------------------------------------------------
    // Registered scan state and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx         <= '0;
            r_shadow      <= '0;
            r_blink_phase <= 1'b0;
            r_out         <= SLOT_OUT_RESET;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;

            if (w_blink_tick) begin
                r_blink_phase <= ~r_blink_phase;
            end

            if (w_refresh_tick) begin
                r_idx <= w_next_idx;
                r_out <= w_next_out;
                if (w_frame_edge) begin
                    r_shadow      <= digits_in;
                    r_frame_start <= 1'b1;
                end
            end
        end
    end

    assign digit       = r_out.digit;
    assign an          = r_out.an;
    assign dp_n        = r_out.dp_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_display_scan_mux
//
// Directed bench for display_scan_mux with REFRESH_DIV=4, BLINK_DIV=16, plus a
// second instance built with REFRESH_DIV=1. Inputs change #1 after a rising
// edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_display_scan_mux;

    localparam int RDIV = 4;
    localparam int BDIV = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic        blank_lead;

    logic [3:0]  digit, an;
    logic        dp_n, frame_start;
    logic [3:0]  digit_f, an_f;
    logic        dp_n_f, frame_start_f;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;   // rising edges since rst was released

    always #5 clk = ~clk;

    display_scan_mux #(
        .REFRESH_DIV (RDIV),
        .BLINK_DIV   (BDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .blink_mask  (blink_mask),
        .dp_mask     (dp_mask),
        .blank_lead  (blank_lead),
        .digit       (digit),
        .an          (an),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    display_scan_mux #(
        .REFRESH_DIV (1),
        .BLINK_DIV   (BDIV)
    ) dut_fast (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .blink_mask  (blink_mask),
        .dp_mask     (dp_mask),
        .blank_lead  (blank_lead),
        .digit       (digit_f),
        .an          (an_f),
        .dp_n        (dp_n_f),
        .frame_start (frame_start_f)
    );

    typedef struct packed {
        logic [15:0] din;
        logic [3:0]  dp;
        logic        bl;
        logic [15:0] ed;   // expected digit per slot, nibble k = slot k
        logic [15:0] ea;   // expected an per slot, nibble k = slot k
        logic [3:0]  ep;   // expected dp_n per slot, bit k = slot k
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        if (rst) cyc = 0;
        else     cyc++;
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_slot(input string name, input logic [3:0] ea,
                            input logic [3:0] ed, input logic ep);
        chk({name, ".an"},    an,            ea);
        chk({name, ".digit"}, digit,         ed);
        chk({name, ".dp_n"},  {3'b0, dp_n},  {3'b0, ep});
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 40);
        chk({name, ".frame_start_seen"}, {3'b0, frame_start}, 4'd1);
    endtask

    task automatic chk_reset(input string name);
        chk_slot(name, 4'b1111, 4'd0, 1'b1);
        chk({name, ".fs"},      {3'b0, frame_start},   4'd0);
        chk({name, ".f_an"},    an_f,                  4'b1111);
        chk({name, ".f_digit"}, digit_f,               4'd0);
        chk({name, ".f_dp_n"},  {3'b0, dp_n_f},        4'd1);
        chk({name, ".f_fs"},    {3'b0, frame_start_f}, 4'd0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0100, 1'b0, 16'h1234, 16'h7BDE, 4'b1011};
        vecs[1] = '{16'h0930, 4'b0000, 1'b1, 16'h0930, 16'hFBDE, 4'b1111};
        vecs[2] = '{16'h1930, 4'b1000, 1'b1, 16'h1930, 16'h7BDE, 4'b0111};
        vecs[3] = '{16'h0ABF, 4'b1111, 1'b1, 16'h0ABF, 16'hFBDE, 4'b1000};
        vecs[4] = '{16'h0ABF, 4'b0001, 1'b0, 16'h0ABF, 16'h7BDE, 4'b1110};
        vecs[5] = '{16'h5000, 4'b0000, 1'b1, 16'h5000, 16'h7BDE, 4'b1111};

        // ---- reset and first frame ----
        rst        = 1'b1;
        digits_in  = 16'h1234;
        blink_mask = 4'b0000;
        dp_mask    = 4'b0000;
        blank_lead = 1'b0;
        repeat (3) step();
        chk_reset("reset");
        rst = 1'b0;

        wait_until(3);
        chk("pre_tick.an", an, 4'b1111);
        wait_until(4);
        chk_slot("tick1", 4'b1101, 4'd0, 1'b1);
        wait_until(8);
        chk_slot("tick2", 4'b1011, 4'd0, 1'b1);
        wait_until(12);
        chk_slot("tick3", 4'b0111, 4'd0, 1'b1);
        wait_until(16);
        chk_slot("f1.s0", 4'b1110, 4'd4, 1'b1);
        chk("f1.fs", {3'b0, frame_start}, 4'd1);
        wait_until(17);
        chk("f1.fs_clear", {3'b0, frame_start}, 4'd0);

        // ---- mid-frame change must not tear the frame ----
        wait_until(20);
        chk_slot("f1.s1", 4'b1101, 4'd3, 1'b1);
        digits_in = 16'h5678;
        wait_until(24);
        chk_slot("tear.s2", 4'b1011, 4'd2, 1'b1);
        wait_until(28);
        chk_slot("tear.s3", 4'b0111, 4'd1, 1'b1);
        wait_until(32);
        chk_slot("f2.s0", 4'b1110, 4'd8, 1'b1);
        wait_until(36);
        chk_slot("f2.s1", 4'b1101, 4'd7, 1'b1);
        wait_until(40);
        chk_slot("f2.s2", 4'b1011, 4'd6, 1'b1);
        wait_until(44);
        chk_slot("f2.s3", 4'b0111, 4'd5, 1'b1);

        // ---- table of full frames: dp, leading-zero blank, values 10-15 ----
        for (int i = 0; i < 6; i++) begin
            digits_in  = vecs[i].din;
            dp_mask    = vecs[i].dp;
            blank_lead = vecs[i].bl;
            wait_frame($sformatf("vec%0d", i));
            for (int k = 0; k < 4; k++) begin
                if (k > 0) repeat (RDIV) step();
                chk_slot($sformatf("vec%0d.s%0d", i, k),
                         vecs[i].ea[4*k +: 4], vecs[i].ed[4*k +: 4], vecs[i].ep[k]);
            end
        end

        // ---- blink on slots 0/1 over a full 32-cycle blink period ----
        digits_in  = 16'h1234;
        dp_mask    = 4'b0001;
        blank_lead = 1'b0;
        blink_mask = 4'b0011;
        for (int n = 0; n < 32; n++) begin
            step();
            if (cyc % RDIV == 0) begin
                int   k;
                logic ph, blk;
                logic [3:0] oh;
                k   = (cyc / RDIV) % 4;
                ph  = (((cyc - 1) / BDIV) % 2) == 1;
                blk = ph && (k < 2);
                oh  = 4'b0001 << k;
                chk($sformatf("blink.s%0d.ph%0d.an", k, ph), an, blk ? 4'b1111 : ~oh);
                chk($sformatf("blink.s%0d.ph%0d.dp_n", k, ph), {3'b0, dp_n},
                    (blk || k != 0) ? 4'd1 : 4'd0);
            end
        end

        // ---- dp on slot 2, then reset in the middle of slot 2 ----
        blink_mask = 4'b0000;
        dp_mask    = 4'b0100;
        begin
            int n;
            n = 0;
            do begin
                step();
                n++;
            end while (an !== 4'b1011 && n < 24);
            chk("rst_mid.reach_s2", an, 4'b1011);
            chk("rst_mid.s2_dp_n", {3'b0, dp_n}, 4'd0);
        end
        step();
        rst = 1'b1;
        step();
        chk_reset("rst_mid");
        rst = 1'b0;

        // ---- restart from idx 0; fast instance advances every cycle ----
        for (int n = 0; n < 8; n++) begin
            logic [3:0] oh;
            step();
            oh = 4'b0001 << (cyc % 4);
            chk($sformatf("fast.c%0d.an", cyc), an_f, ~oh);
            chk($sformatf("fast.c%0d.fs", cyc), {3'b0, frame_start_f},
                (cyc % 4 == 0) ? 4'd1 : 4'd0);
            if (cyc == 3) chk("restart.pre_tick.an", an, 4'b1111);
            if (cyc == 4) chk_slot("restart.tick1", 4'b1101, 4'd0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
